branch_update_queue: RTL and testbench

Buffers resolved conditional branches coming out of the execute stage and drains them, one per cycle, into the BHT update port (UPDATE_VALID / UPDATE_PC / UPDATE_TAKEN). It decouples execute-stage resolution bursts from the single-write-per-cycle counter table. It also flags mispredictions by comparing the actual outcome with the fetch-time prediction.

---
 rtl/branch_update_queue.sv | 199 +++++++++++++++++++
 tb/tb_branch_update_queue.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_update_queue.sv
// branch_update_queue
// Buffers resolved conditional branches from execute and drains them, one per
// cycle, into the BHT update port. It also flags mispredicted branches as they
// are accepted.
//
// Optional feature macro: BRANCH_STATS_EN
//   defined   -> saturating BRANCH_COUNT / MISPREDICT_COUNT counters
//   undefined -> both statistics ports tie to zero and no counter flops exist
module branch_update_queue #(
    parameter int DEPTH      = 8,
    parameter int PC_WIDTH   = 64,
    parameter int STAT_WIDTH = 32
) (
    input  logic                      CLOCK,
    input  logic                      RESET,
    input  logic                      FLUSH,
    input  logic                      RES_VALID,
    output logic                      RES_READY,
    input  logic [PC_WIDTH-1:0]       RES_PC,
    input  logic                      RES_TAKEN,
    input  logic                      RES_PRED_TAKEN,
    input  logic                      DRAIN_HOLD,
    output logic                      UPDATE_VALID,
    output logic [PC_WIDTH-1:0]       UPDATE_PC,
    output logic                      UPDATE_TAKEN,
    output logic                      MISPREDICT,
    output logic [$clog2(DEPTH):0]    OCCUPANCY,
    output logic [STAT_WIDTH-1:0]     BRANCH_COUNT,
    output logic [STAT_WIDTH-1:0]     MISPREDICT_COUNT
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam int EW = PC_WIDTH + 1;

    localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);
    localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

    // Advance a circular pointer, wrapping from the last slot back to zero.
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
        logic [AW-1:0] nxt;
        if (ptr == LAST_C) begin
            nxt = {AW{1'b0}};
        end else begin
            nxt = ptr + AW'(1);
        end
        return nxt;
    endfunction

    // Storage: each entry packs {PC, TAKEN}.
    logic [EW-1:0] entry_mem_r [DEPTH];

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [OW-1:0] occ_r;

    logic          update_valid_r;
    logic [PC_WIDTH-1:0] update_pc_r;
    logic          update_taken_r;
    logic          mispredict_r;

    logic          ready_s;
    logic          push_s;
    logic          pop_s;
    logic          mispred_s;
    logic [OW-1:0] occ_next_s;
    logic [EW-1:0] head_s;

    // Handshake, drain and occupancy decisions for this cycle.
    always_comb begin
        ready_s    = 1'b0;
        push_s     = 1'b0;
        pop_s      = 1'b0;
        mispred_s  = 1'b0;
        occ_next_s = occ_r;
        head_s     = entry_mem_r[rd_ptr_r];

        // Full means not ready, even if a pop happens this edge (no pass-through).
        if ((occ_r < DEPTH_C) && !FLUSH) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end

        push_s    = RES_VALID && ready_s;
        pop_s     = (occ_r != {OW{1'b0}}) && !DRAIN_HOLD && !FLUSH;
        mispred_s = push_s && (RES_TAKEN != RES_PRED_TAKEN);

        if (FLUSH) begin
            occ_next_s = {OW{1'b0}};
        end else if (push_s && !pop_s) begin
            occ_next_s = occ_r + OW'(1);
        end else if (pop_s && !push_s) begin
            occ_next_s = occ_r - OW'(1);
        end else begin
            occ_next_s = occ_r;
        end
    end

    // Entry write port; data needs no reset because occupancy qualifies it.
    always_ff @(posedge CLOCK) begin
        if (push_s && !RESET) begin
            entry_mem_r[wr_ptr_r] <= {RES_PC, RES_TAKEN};
        end else begin
            entry_mem_r[wr_ptr_r] <= entry_mem_r[wr_ptr_r];
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the queue.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            occ_r    <= {OW{1'b0}};
        end else if (FLUSH) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            occ_r    <= {OW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            occ_r <= occ_next_s;
        end
    end

    // BHT update port: one-cycle strobe per pop, data holds between pops.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            update_valid_r <= 1'b0;
            update_pc_r    <= {PC_WIDTH{1'b0}};
            update_taken_r <= 1'b0;
        end else if (pop_s) begin
            update_valid_r <= 1'b1;
            update_pc_r    <= head_s[EW-1:1];
            update_taken_r <= head_s[0];
        end else begin
            update_valid_r <= 1'b0;
            update_pc_r    <= update_pc_r;
            update_taken_r <= update_taken_r;
        end
    end

    // Misprediction pulse for the branch accepted on the previous edge.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            mispredict_r <= 1'b0;
        end else begin
            mispredict_r <= mispred_s;
        end
    end

    assign RES_READY    = ready_s;
    assign UPDATE_VALID = update_valid_r;
    assign UPDATE_PC    = update_pc_r;
    assign UPDATE_TAKEN = update_taken_r;
    assign MISPREDICT   = mispredict_r;
    assign OCCUPANCY    = occ_r;

`ifdef BRANCH_STATS_EN
    localparam logic [STAT_WIDTH-1:0] STAT_MAX_C = {STAT_WIDTH{1'b1}};

    logic [STAT_WIDTH-1:0] branch_cnt_r;
    logic [STAT_WIDTH-1:0] mispred_cnt_r;

    // Saturating statistics; only RESET clears them, flush leaves them alone.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            branch_cnt_r  <= {STAT_WIDTH{1'b0}};
            mispred_cnt_r <= {STAT_WIDTH{1'b0}};
        end else begin
            if (push_s && (branch_cnt_r != STAT_MAX_C)) begin
                branch_cnt_r <= branch_cnt_r + STAT_WIDTH'(1);
            end else begin
                branch_cnt_r <= branch_cnt_r;
            end
            if (mispred_s && (mispred_cnt_r != STAT_MAX_C)) begin
                mispred_cnt_r <= mispred_cnt_r + STAT_WIDTH'(1);
            end else begin
                mispred_cnt_r <= mispred_cnt_r;
            end
        end
    end

    assign BRANCH_COUNT     = branch_cnt_r;
    assign MISPREDICT_COUNT = mispred_cnt_r;
`else
    assign BRANCH_COUNT     = {STAT_WIDTH{1'b0}};
    assign MISPREDICT_COUNT = {STAT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_branch_update_queue.sv
// Directed, table-driven bench for branch_update_queue (DEPTH=8, PC_WIDTH=64).
module tb_branch_update_queue;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        FLUSH;
    logic        RES_VALID;
    logic        RES_READY;
    logic [63:0] RES_PC;
    logic        RES_TAKEN;
    logic        RES_PRED_TAKEN;
    logic        DRAIN_HOLD;
    logic        UPDATE_VALID;
    logic [63:0] UPDATE_PC;
    logic        UPDATE_TAKEN;
    logic        MISPREDICT;
    logic [3:0]  OCCUPANCY;
    logic [31:0] BRANCH_COUNT;
    logic [31:0] MISPREDICT_COUNT;

    int errors = 0;
    int checks = 0;
    int exp_branch = 0;
    int exp_mis = 0;

`ifdef BRANCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    branch_update_queue #(.DEPTH(8), .PC_WIDTH(64), .STAT_WIDTH(32)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .FLUSH(FLUSH),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_PC(RES_PC),
        .RES_TAKEN(RES_TAKEN), .RES_PRED_TAKEN(RES_PRED_TAKEN),
        .DRAIN_HOLD(DRAIN_HOLD), .UPDATE_VALID(UPDATE_VALID),
        .UPDATE_PC(UPDATE_PC), .UPDATE_TAKEN(UPDATE_TAKEN),
        .MISPREDICT(MISPREDICT), .OCCUPANCY(OCCUPANCY),
        .BRANCH_COUNT(BRANCH_COUNT), .MISPREDICT_COUNT(MISPREDICT_COUNT)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic        flush, valid;
        logic [63:0] pc;
        logic        taken, pred, hold;
        logic        e_ready, e_uvalid;
        logic [63:0] e_upc;
        logic        e_utaken, e_mp;
        logic [3:0]  e_occ;
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mk(input logic fl, input logic va, input logic [63:0] pc,
                                input logic tk, input logic pr, input logic ho,
                                input logic er, input logic eu, input logic [63:0] ep,
                                input logic et, input logic em, input logic [3:0] eo);
        vec_t v;
        v.flush = fl; v.valid = va; v.pc = pc; v.taken = tk; v.pred = pr; v.hold = ho;
        v.e_ready = er; v.e_uvalid = eu; v.e_upc = ep; v.e_utaken = et;
        v.e_mp = em; v.e_occ = eo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic chk_stats(input string name);
        chk({name, "_branch_count"}, 64'(BRANCH_COUNT), STATS ? 64'(exp_branch) : 64'd0);
        chk({name, "_mispredict_count"}, 64'(MISPREDICT_COUNT), STATS ? 64'(exp_mis) : 64'd0);
    endtask

    task automatic drive(input logic va, input logic [63:0] pc, input logic tk, input logic pr);
        RES_VALID = va; RES_PC = pc; RES_TAKEN = tk; RES_PRED_TAKEN = pr;
    endtask

    initial begin
        RESET = 1'b1; FLUSH = 1'b0; DRAIN_HOLD = 1'b0;
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        tick(); tick();
        RESET = 1'b0;
        #1;
        chk("rst_ready", 64'(RES_READY), 64'd1);
        chk("rst_uvalid", 64'(UPDATE_VALID), 64'd0);
        chk("rst_upc", UPDATE_PC, 64'd0);
        chk("rst_utaken", 64'(UPDATE_TAKEN), 64'd0);
        chk("rst_mispredict", 64'(MISPREDICT), 64'd0);
        chk("rst_occupancy", 64'(OCCUPANCY), 64'd0);
        chk_stats("rst");

        // flush valid pc taken pred hold | ready uvalid upc utaken mp occ
        vecs[0] = mk(0, 1, 64'h1000, 1, 1, 0,  1, 0, 64'h0,    0, 0, 4'd1);
        vecs[1] = mk(0, 0, 64'h0,    0, 0, 0,  1, 1, 64'h1000, 1, 0, 4'd0);
        vecs[2] = mk(0, 0, 64'h0,    0, 0, 0,  1, 0, 64'h1000, 1, 0, 4'd0);
        vecs[3] = mk(0, 1, 64'h2000, 0, 1, 0,  1, 0, 64'h1000, 1, 1, 4'd1);
        vecs[4] = mk(0, 1, 64'h3000, 1, 1, 0,  1, 1, 64'h2000, 0, 0, 4'd1);
        vecs[5] = mk(0, 1, 64'h4000, 0, 1, 1,  1, 0, 64'h2000, 0, 1, 4'd2);
        vecs[6] = mk(0, 0, 64'h0,    0, 0, 0,  1, 1, 64'h3000, 1, 0, 4'd1);
        vecs[7] = mk(1, 1, 64'h5000, 1, 0, 0,  0, 0, 64'h3000, 1, 0, 4'd0);
        vecs[8] = mk(0, 0, 64'h0,    0, 0, 0,  1, 0, 64'h3000, 1, 0, 4'd0);

        for (int i = 0; i < 9; i++) begin
            FLUSH = vecs[i].flush; DRAIN_HOLD = vecs[i].hold;
            drive(vecs[i].valid, vecs[i].pc, vecs[i].taken, vecs[i].pred);
            #1;
            chk($sformatf("v%0d_ready", i), 64'(RES_READY), 64'(vecs[i].e_ready));
            if (vecs[i].valid && vecs[i].e_ready) begin
                exp_branch++;
                if (vecs[i].taken != vecs[i].pred) exp_mis++;
            end
            tick();
            chk($sformatf("v%0d_uvalid", i), 64'(UPDATE_VALID), 64'(vecs[i].e_uvalid));
            chk($sformatf("v%0d_upc", i), UPDATE_PC, vecs[i].e_upc);
            chk($sformatf("v%0d_utaken", i), 64'(UPDATE_TAKEN), 64'(vecs[i].e_utaken));
            chk($sformatf("v%0d_mispredict", i), 64'(MISPREDICT), 64'(vecs[i].e_mp));
            chk($sformatf("v%0d_occupancy", i), 64'(OCCUPANCY), 64'(vecs[i].e_occ));
        end
        FLUSH = 1'b0;
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        chk_stats("table");

        // Fill to full under DRAIN_HOLD, then drain in order.
        DRAIN_HOLD = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 64'h100 + 64'(i) * 64'h10, i[0], 1'b1);
            exp_branch++;
            if (!i[0]) exp_mis++;
            tick();
        end
        chk("full_occupancy", 64'(OCCUPANCY), 64'd8);
        chk("full_ready", 64'(RES_READY), 64'd0);
        drive(1'b1, 64'h999, 1'b1, 1'b0);
        tick();
        chk("full_stall_occupancy", 64'(OCCUPANCY), 64'd8);
        chk("full_stall_mispredict", 64'(MISPREDICT), 64'd0);
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        DRAIN_HOLD = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("drain%0d_uvalid", i), 64'(UPDATE_VALID), 64'd1);
            chk($sformatf("drain%0d_upc", i), UPDATE_PC, 64'h100 + 64'(i) * 64'h10);
            chk($sformatf("drain%0d_utaken", i), 64'(UPDATE_TAKEN), 64'(i[0]));
            if (i == 0) chk("drain_ready_after_pop", 64'(RES_READY), 64'd1);
        end
        tick();
        chk("drain_done_uvalid", 64'(UPDATE_VALID), 64'd0);
        chk("drain_done_occupancy", 64'(OCCUPANCY), 64'd0);
        chk_stats("fill");

        // Continuous push and pop across pointer wrap.
        drive(1'b1, 64'hA000, 1'b0, 1'b0);
        exp_branch++;
        tick();
        chk("wrap_start_occupancy", 64'(OCCUPANCY), 64'd1);
        for (int i = 1; i <= 20; i++) begin
            drive(1'b1, 64'hA000 + 64'(i), i[0], i[0]);
            exp_branch++;
            tick();
            chk($sformatf("wrap%0d_uvalid", i), 64'(UPDATE_VALID), 64'd1);
            chk($sformatf("wrap%0d_upc", i), UPDATE_PC, 64'hA000 + 64'(i - 1));
            chk($sformatf("wrap%0d_utaken", i), 64'(UPDATE_TAKEN), 64'((i - 1) % 2));
            chk($sformatf("wrap%0d_occupancy", i), 64'(OCCUPANCY), 64'd1);
        end
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        tick();
        chk("wrap_last_upc", UPDATE_PC, 64'hA014);
        chk("wrap_last_occupancy", 64'(OCCUPANCY), 64'd0);

        // Flush with 5 queued and a simultaneous offer.
        DRAIN_HOLD = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 64'hB000 + 64'(i), 1'b1, 1'b1);
            exp_branch++;
            tick();
        end
        chk("preflush_occupancy", 64'(OCCUPANCY), 64'd5);
        FLUSH = 1'b1; DRAIN_HOLD = 1'b0;
        drive(1'b1, 64'hBEEF, 1'b1, 1'b0);
        #1;
        chk("flush_ready", 64'(RES_READY), 64'd0);
        tick();
        chk("flush_occupancy", 64'(OCCUPANCY), 64'd0);
        chk("flush_uvalid", 64'(UPDATE_VALID), 64'd0);
        chk("flush_mispredict", 64'(MISPREDICT), 64'd0);
        FLUSH = 1'b0;
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("postflush%0d_uvalid", i), 64'(UPDATE_VALID), 64'd0);
        end
        chk_stats("flush");

        // Reset while entries are queued and an update is on the port.
        DRAIN_HOLD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'hC000 + 64'(i), 1'b0, 1'b1);
            tick();
        end
        DRAIN_HOLD = 1'b0;
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        tick();
        chk("prerst_uvalid", 64'(UPDATE_VALID), 64'd1);
        chk("prerst_upc", UPDATE_PC, 64'hC000);
        chk("prerst_occupancy", 64'(OCCUPANCY), 64'd2);
        RESET = 1'b1;
        drive(1'b1, 64'hD000, 1'b1, 1'b0);
        tick();
        exp_branch = 0; exp_mis = 0;
        chk("rst2_uvalid", 64'(UPDATE_VALID), 64'd0);
        chk("rst2_upc", UPDATE_PC, 64'd0);
        chk("rst2_utaken", 64'(UPDATE_TAKEN), 64'd0);
        chk("rst2_mispredict", 64'(MISPREDICT), 64'd0);
        chk("rst2_occupancy", 64'(OCCUPANCY), 64'd0);
        chk_stats("rst2");
        RESET = 1'b0;
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        #1;
        chk("rst2_ready", 64'(RES_READY), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("postrst%0d_uvalid", i), 64'(UPDATE_VALID), 64'd0);
            chk($sformatf("postrst%0d_occupancy", i), 64'(OCCUPANCY), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
